reg_alu: RTL and testbench
==========================

REG_ALU -- requirements
Module: reg_alu

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  system clock; regfile writes on falling edge.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 write  in  1  regfile write enable, 1 = write result into rDst.
REQ-005 IMM_MUX  in  1  operand B select: 0 = dSrc, 1 = imm.
REQ-006 WB_MUX  in  2  writeback select: 00 = pc1, 01 = imm, 10 = ALU result, 11 = mem_data.
REQ-007 rSrc  in  4  source register index.
REQ-008 rDst  in  4  destination register index; also operand A.
REQ-009 aluOp  in  5  ALU operation code.
REQ-010 pc1  in  16  PC+1 for link writeback.
REQ-011 imm  in  16  immediate operand.
REQ-012 mem_data  in  16  load data for writeback.
REQ-013 dSrc  out  16  combinational read of reg[rSrc].
REQ-014 dDst  out  16  combinational read of reg[rDst].
REQ-015 psrOut  out  5  combinational flags {N,Z,F,L,C} at bits [4:0].

Function
REQ-016 The regfile SHALL hold 16 x 16-bit registers with two combinational read ports (dSrc, dDst).
REQ-017 The regfile SHALL write the selected WB value into reg[rDst] on each falling clk edge with write=1; reads reflect it from that edge, with no bypass.
REQ-018 Operands: A = dDst; B = IMM_MUX ? imm : dSrc.
REQ-019 ALU ops SHALL be: ADD 00000 (A+B); SUB 00001 (A-B); AND 00010; OR 00011; XOR 00100; NOT 00101 (~B); MOV 00110 (B); LUI 00111 ({B[7:0],8'h00}); SLL 01000; SRL 01001; SRA 01010 (shift A by B[3:0], SRA sign-fills); others -> result 0.
REQ-020 All arithmetic SHALL be 16-bit modulo, with the carry-out kept for C.
REQ-021 psrOut SHALL update combinationally for every aluOp, whether or not write=1.
REQ-022 Comparison flags: N = signed(A) < signed(B); Z = (A == B); L = unsigned(A) < unsigned(B).
REQ-023 C SHALL be the ADD carry-out or the SUB borrow, and 0 for all other ops.
REQ-024 F SHALL be the signed overflow of ADD or SUB, and 0 for all other ops.
REQ-025 When write=1 and rDst == rSrc, the new value SHALL appear on both read ports after the falling edge.

Reset
REQ-026 rst=0 SHALL asynchronously clear all 16 registers to 0x0000, making dSrc = dDst = 0 and psrOut = 01000 for aluOp = 00000 with IMM_MUX = 0.
REQ-027 A falling clk edge during reset SHALL perform no write.
REQ-028 Deassertion SHALL take effect on the next falling edge.

Configuration
REQ-029 Macro REG_ALU_R0_ZERO_EN: defined -> reg[0] is hardwired to 0 and writes to it are ignored; undefined -> r0 is an ordinary register.

Structure
REQ-030 Shared package reg_alu_pkg SHALL hold the aluOp encodings, the WB_MUX encodings and the PSR bit indices.
REQ-031 The combinational ALU plus flag logic SHALL be one sub-module, alu16; the regfile and muxes stay in reg_alu.

Verification
REQ-032 After reset: ADD r1 with imm 10 (IMM_MUX=1, WB=10, write=1) -> psrOut=10010 before the falling edge; dDst=0x000A after it.
REQ-033 LUI r2 with imm 255 -> dDst=0xFF00; then rDst=1, rSrc=2, aluOp=0, write=0 -> dSrc=0xFF00, dDst=0x000A, psrOut=00010.
REQ-034 WB=11, mem_data=10, rDst=3, write=1 -> r3=0x000A; then rDst=1, rSrc=3 -> psrOut=01000.
REQ-035 MOV r4 with imm 1, then SLL r4 by 15 -> 0x8000, then SRA r4 by 15 -> 0xFFFF; psrOut before the SRA edge = 10000.
REQ-036 ADD of 0x7FFF and imm 1 -> psrOut F=1, C=0, result 0x8000; ADD of 0xFFFF and imm 1 -> C=1, result 0x0000.
REQ-037 Reset asserted mid-sequence -> all registers read 0 immediately; WB=00, pc1=0x1234 -> reg[rDst]=0x1234.

Source files
------------

// File: rtl/reg_alu_pkg.sv
// Shared encodings for reg_alu: ALU opcodes, writeback selects and PSR flag positions.
package reg_alu_pkg;

   typedef enum logic [4:0] {
      OP_ADD = 5'b00000,
      OP_SUB = 5'b00001,
      OP_AND = 5'b00010,
      OP_OR  = 5'b00011,
      OP_XOR = 5'b00100,
      OP_NOT = 5'b00101,
      OP_MOV = 5'b00110,
      OP_LUI = 5'b00111,
      OP_SLL = 5'b01000,
      OP_SRL = 5'b01001,
      OP_SRA = 5'b01010
   } alu_op_e;

   typedef enum logic [1:0] {
      WB_PC1 = 2'b00,
      WB_IMM = 2'b01,
      WB_ALU = 2'b10,
      WB_MEM = 2'b11
   } wb_sel_e;

   localparam int PSR_N = 4;
   localparam int PSR_Z = 3;
   localparam int PSR_F = 2;
   localparam int PSR_L = 1;
   localparam int PSR_C = 0;

endpackage

// File: rtl/reg_alu_alu.sv
// alu16: combinational 16-bit ALU with {N,Z,F,L,C} flags; N/Z/L always compare A and B.
module alu16
   import reg_alu_pkg::*;
(
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [4:0]  op,
   output logic [15:0] result,
   output logic [4:0]  psr
);

   logic [16:0] sum_s;
   logic [16:0] diff_s;

   assign sum_s  = {1'b0, a} + {1'b0, b};
   assign diff_s = {1'b0, a} - {1'b0, b};

   // Result select plus flags; C and F only carry meaning for ADD/SUB.
   always_comb begin
      result       = 16'h0000;
      psr          = 5'b00000;
      psr[PSR_N]   = ($signed(a) < $signed(b));
      psr[PSR_Z]   = (a == b);
      psr[PSR_L]   = (a < b);
      case (op)
         OP_ADD: begin
            result     = sum_s[15:0];
            psr[PSR_C] = sum_s[16];
            psr[PSR_F] = (a[15] == b[15]) && (sum_s[15] != a[15]);
         end
         OP_SUB: begin
            result     = diff_s[15:0];
            psr[PSR_C] = diff_s[16];
            psr[PSR_F] = (a[15] != b[15]) && (diff_s[15] != a[15]);
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOT:  result = ~b;
         OP_MOV:  result = b;
         OP_LUI:  result = {b[7:0], 8'h00};
         OP_SLL:  result = a << b[3:0];
         OP_SRL:  result = a >> b[3:0];
         OP_SRA:  result = $signed(a) >>> b[3:0];
         default: result = 16'h0000;
      endcase
   end

endmodule

// File: rtl/reg_alu.sv
// reg_alu: 16x16 regfile written on the falling clock edge, operand/writeback muxes around alu16.
// Optional REG_ALU_R0_ZERO_EN hardwires r0 to zero.
module reg_alu
   import reg_alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        write,
   input  logic        IMM_MUX,
   input  logic [1:0]  WB_MUX,
   input  logic [3:0]  rSrc,
   input  logic [3:0]  rDst,
   input  logic [4:0]  aluOp,
   input  logic [15:0] pc1,
   input  logic [15:0] imm,
   input  logic [15:0] mem_data,
   output logic [15:0] dSrc,
   output logic [15:0] dDst,
   output logic [4:0]  psrOut
);

   logic [15:0] regs_q [16];
   logic [15:0] regs_d [16];
   logic [15:0] op_b_s;
   logic [15:0] alu_res_s;
   logic [15:0] wb_s;

   assign dSrc = regs_q[rSrc];
   assign dDst = regs_q[rDst];

   // Operand B and writeback source selection.
   always_comb begin
      if (IMM_MUX) begin
         op_b_s = imm;
      end else begin
         op_b_s = dSrc;
      end
      case (WB_MUX)
         WB_PC1:  wb_s = pc1;
         WB_IMM:  wb_s = imm;
         WB_ALU:  wb_s = alu_res_s;
         WB_MEM:  wb_s = mem_data;
         default: wb_s = 16'h0000;
      endcase
   end

   alu16 u_alu (
      .a      (dDst),
      .b      (op_b_s),
      .op     (aluOp),
      .result (alu_res_s),
      .psr    (psrOut)
   );

   // Next regfile contents; no read bypass, the write lands at the falling edge.
   always_comb begin
      regs_d = regs_q;
      if (write) begin
         regs_d[rDst] = wb_s;
      end else begin
         regs_d = regs_q;
      end
`ifdef REG_ALU_R0_ZERO_EN
      regs_d[0] = 16'h0000;
`endif
   end

   // Regfile storage, cleared asynchronously while rst is low.
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 16; i++) begin
            regs_q[i] <= 16'h0000;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

endmodule

// File: tb/tb_reg_alu.sv
// Self-checking bench for reg_alu: vector table with scoreboard plus reset sequences.
module tb_reg_alu;

   logic        clk;
   logic        rst;
   logic        write;
   logic        IMM_MUX;
   logic [1:0]  WB_MUX;
   logic [3:0]  rSrc;
   logic [3:0]  rDst;
   logic [4:0]  aluOp;
   logic [15:0] pc1;
   logic [15:0] imm;
   logic [15:0] mem_data;
   logic [15:0] dSrc;
   logic [15:0] dDst;
   logic [4:0]  psrOut;

   reg_alu dut (
      .clk      (clk),
      .rst      (rst),
      .write    (write),
      .IMM_MUX  (IMM_MUX),
      .WB_MUX   (WB_MUX),
      .rSrc     (rSrc),
      .rDst     (rDst),
      .aluOp    (aluOp),
      .pc1      (pc1),
      .imm      (imm),
      .mem_data (mem_data),
      .dSrc     (dSrc),
      .dDst     (dDst),
      .psrOut   (psrOut)
   );

   typedef struct {
      logic        wr;
      logic        imm_mux;
      logic [1:0]  wb;
      logic [3:0]  rsrc;
      logic [3:0]  rdst;
      logic [4:0]  op;
      logic [15:0] pc1;
      logic [15:0] imm;
      logic [15:0] mem;
      logic [4:0]  psr;
      logic [15:0] dsrc;
      logic [15:0] ddst;
   } vec_t;

   typedef struct {
      logic [4:0]  psr;
      logic [15:0] dsrc;
      logic [15:0] ddst;
   } exp_t;

   localparam int NVEC = 21;
   vec_t vecs [NVEC];
   exp_t sb [$];
   exp_t e;
   logic [4:0] psr_seen;
   int checks_total;
   int checks_passed;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d required none pending", checks_total);
      $fatal(1);
   end

   function automatic vec_t mk(input logic wr, input logic im, input logic [1:0] wb,
                               input logic [3:0] rs, input logic [3:0] rd, input logic [4:0] op,
                               input logic [15:0] p, input logic [15:0] i, input logic [15:0] m,
                               input logic [4:0] ps, input logic [15:0] ds, input logic [15:0] dd);
      vec_t v;
      v.wr = wr; v.imm_mux = im; v.wb = wb; v.rsrc = rs; v.rdst = rd; v.op = op;
      v.pc1 = p; v.imm = i; v.mem = m; v.psr = ps; v.dsrc = ds; v.ddst = dd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks_total++;
      if (act === exp) begin
         checks_passed++;
      end else begin
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      checks_total  = 0;
      checks_passed = 0;
      //          wr    im    wb     rs     rd     op        pc1       imm       mem       psr       dsrc      ddst
      vecs[0]  = mk(1'b1, 1'b1, 2'b10, 4'd0, 4'd1, 5'b00000, 16'h0000, 16'h000A, 16'h0000, 5'b10010, 16'h0000, 16'h000A);
      vecs[1]  = mk(1'b1, 1'b1, 2'b10, 4'd0, 4'd2, 5'b00111, 16'h0000, 16'h00FF, 16'h0000, 5'b10010, 16'h0000, 16'hFF00);
      vecs[2]  = mk(1'b0, 1'b0, 2'b10, 4'd2, 4'd1, 5'b00000, 16'h0000, 16'h0000, 16'h0000, 5'b00010, 16'hFF00, 16'h000A);
      vecs[3]  = mk(1'b1, 1'b0, 2'b11, 4'd0, 4'd3, 5'b00000, 16'h0000, 16'h0000, 16'h000A, 5'b01000, 16'h0000, 16'h000A);
      vecs[4]  = mk(1'b0, 1'b0, 2'b10, 4'd3, 4'd1, 5'b00000, 16'h0000, 16'h0000, 16'h0000, 5'b01000, 16'h000A, 16'h000A);
      vecs[5]  = mk(1'b1, 1'b1, 2'b10, 4'd0, 4'd4, 5'b00110, 16'h0000, 16'h0001, 16'h0000, 5'b10010, 16'h0000, 16'h0001);
      vecs[6]  = mk(1'b1, 1'b1, 2'b10, 4'd0, 4'd4, 5'b01000, 16'h0000, 16'h000F, 16'h0000, 5'b10010, 16'h0000, 16'h8000);
      vecs[7]  = mk(1'b1, 1'b1, 2'b10, 4'd0, 4'd4, 5'b01010, 16'h0000, 16'h000F, 16'h0000, 5'b10000, 16'h0000, 16'hFFFF);
      vecs[8]  = mk(1'b1, 1'b1, 2'b10, 4'd0, 4'd4, 5'b01001, 16'h0000, 16'h0004, 16'h0000, 5'b10000, 16'h0000, 16'h0FFF);
      vecs[9]  = mk(1'b1, 1'b1, 2'b10, 4'd0, 4'd5, 5'b00110, 16'h0000, 16'h7FFF, 16'h0000, 5'b10010, 16'h0000, 16'h7FFF);
      vecs[10] = mk(1'b1, 1'b1, 2'b10, 4'd0, 4'd5, 5'b00000, 16'h0000, 16'h0001, 16'h0000, 5'b00100, 16'h0000, 16'h8000);
      vecs[11] = mk(1'b1, 1'b1, 2'b10, 4'd0, 4'd6, 5'b00110, 16'h0000, 16'hFFFF, 16'h0000, 5'b00010, 16'h0000, 16'hFFFF);
      vecs[12] = mk(1'b1, 1'b1, 2'b10, 4'd0, 4'd6, 5'b00000, 16'h0000, 16'h0001, 16'h0000, 5'b10001, 16'h0000, 16'h0000);
      vecs[13] = mk(1'b1, 1'b1, 2'b10, 4'd0, 4'd1, 5'b00001, 16'h0000, 16'h000B, 16'h0000, 5'b10011, 16'h0000, 16'hFFFF);
      vecs[14] = mk(1'b1, 1'b0, 2'b10, 4'd2, 4'd2, 5'b00100, 16'h0000, 16'h0000, 16'h0000, 5'b01000, 16'h0000, 16'h0000);
      vecs[15] = mk(1'b1, 1'b0, 2'b00, 4'd0, 4'd7, 5'b00000, 16'h1234, 16'h0000, 16'h0000, 5'b01000, 16'h0000, 16'h1234);
      vecs[16] = mk(1'b1, 1'b1, 2'b01, 4'd0, 4'd8, 5'b00010, 16'h0000, 16'hBEEF, 16'h0000, 5'b00010, 16'h0000, 16'hBEEF);
      vecs[17] = mk(1'b1, 1'b1, 2'b10, 4'd0, 4'd8, 5'b11111, 16'h0000, 16'hBEEF, 16'h0000, 5'b01000, 16'h0000, 16'h0000);
      vecs[18] = mk(1'b1, 1'b1, 2'b10, 4'd0, 4'd9, 5'b00101, 16'h0000, 16'h00F0, 16'h0000, 5'b10010, 16'h0000, 16'hFF0F);
      vecs[19] = mk(1'b1, 1'b1, 2'b10, 4'd0, 4'd9, 5'b00011, 16'h0000, 16'h00F0, 16'h0000, 5'b10000, 16'h0000, 16'hFFFF);
      vecs[20] = mk(1'b0, 1'b1, 2'b10, 4'd0, 4'd9, 5'b00000, 16'h0000, 16'h0001, 16'h0000, 5'b10001, 16'h0000, 16'hFFFF);

      // Reset held across a falling edge with write=1: nothing must be written.
      rst = 1'b0; write = 1'b1; IMM_MUX = 1'b0; WB_MUX = 2'b00; rSrc = 4'd1; rDst = 4'd1;
      aluOp = 5'b00000; pc1 = 16'h5555; imm = 16'h0000; mem_data = 16'h0000;
      @(negedge clk); #1;
      chk("reset_ddst", dDst, 16'h0000);
      chk("reset_dsrc", dSrc, 16'h0000);
      chk("reset_psr", {11'd0, psrOut}, {11'd0, 5'b01000});

      // Release reset; the next falling edge performs a write.
      @(posedge clk); #1;
      rst = 1'b1; rDst = 4'd10; rSrc = 4'd0;
      @(negedge clk); #1;
      chk("deassert_write", dDst, 16'h5555);

      for (int k = 0; k < NVEC; k++) begin
         @(posedge clk); #1;
         write = vecs[k].wr; IMM_MUX = vecs[k].imm_mux; WB_MUX = vecs[k].wb;
         rSrc = vecs[k].rsrc; rDst = vecs[k].rdst; aluOp = vecs[k].op;
         pc1 = vecs[k].pc1; imm = vecs[k].imm; mem_data = vecs[k].mem;
         e.psr = vecs[k].psr; e.dsrc = vecs[k].dsrc; e.ddst = vecs[k].ddst;
         sb.push_back(e);
         #2;
         psr_seen = psrOut;
         @(negedge clk); #1;
         e = sb.pop_front();
         chk($sformatf("v%0d_psr", k), {11'd0, psr_seen}, {11'd0, e.psr});
         chk($sformatf("v%0d_dsrc", k), dSrc, e.dsrc);
         chk($sformatf("v%0d_ddst", k), dDst, e.ddst);
      end

      // Asynchronous reset mid-sequence clears every register at once.
      @(posedge clk); #1;
      rst = 1'b0; write = 1'b0; IMM_MUX = 1'b0; aluOp = 5'b00000;
      #1;
      for (int r = 0; r < 16; r++) begin
         rSrc = r[3:0]; rDst = r[3:0];
         #1;
         chk($sformatf("midreset_r%0d", r), dSrc, 16'h0000);
      end
      @(posedge clk); #1;
      rst = 1'b1; write = 1'b1; WB_MUX = 2'b00; pc1 = 16'h1234; rDst = 4'd1; rSrc = 4'd1;
      @(negedge clk); #1;
      chk("post_reset_pc1_ddst", dDst, 16'h1234);
      chk("post_reset_pc1_dsrc", dSrc, 16'h1234);
      write = 1'b0;
      chk("scoreboard_empty", sb.size(), 16'd0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
